// File: rtl/calc_chain_core.sv
// rtl/calc_chain_core.sv - chained-operation calculator core with sticky overflow and optional signed arithmetic
module calc_chain_core #(
   parameter int WIDTH       = 10,
   parameter bit SIGNED_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] btn,
   input  logic [4:0]       opcode,
   output logic [1:0]       state,
   output logic [WIDTH-1:0] displayedNum,
   output logic [WIDTH-1:0] val1,
   output logic [WIDTH-1:0] val2,
   output logic [4:0]       pressedOp,
   output logic             ovf,
   output logic             op_pressed,
   output logic             btn_pressed
);

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_OPW = 2'd1,
      S_B   = 2'd2,
      S_RES = 2'd3
   } state_t;

   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_MUL = 5'b00100;

   state_t           cur_state, nxt_state;
   logic [WIDTH-1:0] btn_q;
   logic [4:0]       opcode_q;
   logic             btn_ev, op_ev, is_arith, is_eq, is_ce;

   logic             ext_a, ext_b;
   logic [WIDTH:0]   sum, diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] f_res;
   logic             f_ovf;

   logic [WIDTH-1:0] val1_n, val2_n, disp_n;
   logic [4:0]       pop_n;
   logic             ovf_n;

   assign btn_ev   = (btn != btn_q);
   assign op_ev    = (opcode_q == 5'd0) && (opcode != 5'd0) &&
                     ((opcode & (opcode - 5'd1)) == 5'd0);
   assign is_arith = |opcode[2:0];
   assign is_eq    = opcode[3];
   assign is_ce    = opcode[4];

   // One extended datapath serves both modes: the extension bit decides signedness
   assign ext_a = SIGNED_MODE & val1[WIDTH-1];
   assign ext_b = SIGNED_MODE & btn[WIDTH-1];
   assign sum   = {ext_a, val1} + {ext_b, btn};
   assign diff  = {ext_a, val1} - {ext_b, btn};
   assign prod  = {{WIDTH{ext_a}}, val1} * {{WIDTH{ext_b}}, btn};

   always_comb begin
      f_res = '0;
      f_ovf = 1'b0;
      case (pressedOp)
         OP_ADD: begin
            f_res = sum[WIDTH-1:0];
            f_ovf = SIGNED_MODE ? (sum[WIDTH] ^ sum[WIDTH-1]) : sum[WIDTH];
         end
         OP_SUB: begin
            f_res = diff[WIDTH-1:0];
            f_ovf = SIGNED_MODE ? (diff[WIDTH] ^ diff[WIDTH-1]) : diff[WIDTH];
         end
         OP_MUL: begin
            f_res = prod[WIDTH-1:0];
            f_ovf = SIGNED_MODE ? !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]))
                                : (|prod[2*WIDTH-1:WIDTH]);
         end
         default: ;
      endcase
   end

   always_comb begin
      nxt_state = cur_state;
      val1_n    = val1;
      val2_n    = val2;
      pop_n     = pressedOp;
      ovf_n     = ovf;
      case (cur_state)
         S_A: if (op_ev) begin
            if (is_arith) begin
               val1_n    = btn;
               pop_n     = opcode;
               nxt_state = S_OPW;
            end else if (is_eq) begin
               val1_n    = btn;
               nxt_state = S_RES;
            end
         end
         S_OPW: if (op_ev) begin
            if (is_arith) pop_n = opcode;
            else if (is_ce) begin
               val1_n    = '0;
               nxt_state = S_A;
            end
         end else if (btn_ev) nxt_state = S_B;
         S_B: if (op_ev) begin
            if (is_arith || is_eq) begin
               val1_n    = f_res;
               val2_n    = btn;
               ovf_n     = ovf | f_ovf;
               nxt_state = is_arith ? S_OPW : S_RES;
               if (is_arith) pop_n = opcode;
            end else if (is_ce) nxt_state = S_OPW;
         end
         S_RES: if (op_ev) begin
            if (is_arith) begin
               pop_n     = opcode;
               nxt_state = S_OPW;
            end else if (is_ce) begin
               val1_n    = '0;
               nxt_state = S_A;
            end
         end else if (btn_ev) nxt_state = S_A;
         default: nxt_state = S_A;
      endcase
      if ((op_ev && is_ce) || nxt_state == S_A) ovf_n = 1'b0;
      disp_n = (nxt_state == S_A || nxt_state == S_B) ? btn : val1_n;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cur_state    <= S_A;
         btn_q        <= '0;
         opcode_q     <= '0;
         displayedNum <= '0;
         val1         <= '0;
         val2         <= '0;
         pressedOp    <= '0;
         ovf          <= 1'b0;
         op_pressed   <= 1'b0;
         btn_pressed  <= 1'b0;
      end else begin
         cur_state    <= nxt_state;
         btn_q        <= btn;
         opcode_q     <= opcode;
         displayedNum <= disp_n;
         val1         <= val1_n;
         val2         <= val2_n;
         pressedOp    <= pop_n;
         ovf          <= ovf_n;
         op_pressed   <= op_ev;
         btn_pressed  <= btn_ev;
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_calc_chain_core.sv
// tb/tb_calc_chain_core.sv - scoreboard bench for calc_chain_core (unsigned W=10 and signed W=8 instances)
module tb_calc_chain_core;

   localparam logic [4:0] ADD = 5'b00001;
   localparam logic [4:0] SUB = 5'b00010;
   localparam logic [4:0] MUL = 5'b00100;
   localparam logic [4:0] EQ  = 5'b01000;
   localparam logic [4:0] CE  = 5'b10000;

   logic       clk = 1'b0;
   logic       clr;
   logic [9:0] btn;
   logic [4:0] opcode;

   logic [1:0] state_a, state_s;
   logic [9:0] disp_a, val1_a, val2_a;
   logic [7:0] disp_s, val1_s, val2_s;
   logic [4:0] pop_a, pop_s;
   logic       ovf_a, ovf_s, opp_a, opp_s, btnp_a, btnp_s;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] val;
      logic       ovf;
      bit         sgn;
   } exp_t;
   exp_t sb[$];

   calc_chain_core #(.WIDTH(10), .SIGNED_MODE(1'b0)) dut (
      .clk(clk), .clr(clr), .btn(btn), .opcode(opcode),
      .state(state_a), .displayedNum(disp_a), .val1(val1_a), .val2(val2_a),
      .pressedOp(pop_a), .ovf(ovf_a), .op_pressed(opp_a), .btn_pressed(btnp_a)
   );

   calc_chain_core #(.WIDTH(8), .SIGNED_MODE(1'b1)) dut_s (
      .clk(clk), .clr(clr), .btn(btn[7:0]), .opcode(opcode),
      .state(state_s), .displayedNum(disp_s), .val1(val1_s), .val2(val2_s),
      .pressedOp(pop_s), .ovf(ovf_s), .op_pressed(opp_s), .btn_pressed(btnp_s)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference arithmetic on exact integers, then range-check and truncate
   function automatic exp_t model(input logic [4:0] op, input int a_raw, input int b_raw,
                                  input int w, input bit sgn);
      exp_t   e;
      longint m, a, b, r, lo, hi;
      m = longint'(1) << w;
      a = a_raw;
      b = b_raw;
      lo = 0;
      hi = m - 1;
      if (sgn) begin
         if (a >= m / 2) a = a - m;
         if (b >= m / 2) b = b - m;
         lo = -(m / 2);
         hi = m / 2 - 1;
      end
      case (op)
         ADD:     r = a + b;
         SUB:     r = a - b;
         default: r = a * b;
      endcase
      e.val = 10'(r & (m - 1));
      e.ovf = (r < lo) || (r > hi);
      e.sgn = sgn;
      return e;
   endfunction

   task automatic set_btn(input int v);
      @(negedge clk);
      btn = 10'(v);
      @(negedge clk);
   endtask

   task automatic press(input logic [4:0] op, input logic pulse);
      @(negedge clk);
      opcode = op;
      @(negedge clk);
      checks++;
      if (opp_a !== pulse) begin
         errors++;
         $display("FAIL op_pressed_%b: got %b expected %b", op, opp_a, pulse);
      end
      @(negedge clk);
      checks++;
      if (opp_a !== 1'b0) begin
         errors++;
         $display("FAIL op_pressed_width_%b: got %b expected 0", op, opp_a);
      end
      repeat (8) @(negedge clk);
      opcode = 5'd0;
      @(negedge clk);
   endtask

   task automatic check_result(input string name, input logic [1:0] st);
      exp_t       e;
      int         n;
      logic [1:0] s;
      logic [9:0] v;
      logic       o;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      e = sb.pop_front();
      n = 0;
      s = e.sgn ? state_s : state_a;
      while (s !== st && n < 20) begin
         @(negedge clk);
         n++;
         s = e.sgn ? state_s : state_a;
      end
      v = e.sgn ? {2'b00, val1_s} : val1_a;
      o = e.sgn ? ovf_s : ovf_a;
      checks++;
      if (s !== st) begin
         errors++;
         $display("FAIL %s_state: got %0d expected %0d", name, s, st);
      end
      checks++;
      if (v !== e.val) begin
         errors++;
         $display("FAIL %s_val1: got %0d expected %0d", name, v, e.val);
      end
      checks++;
      if (o !== e.ovf) begin
         errors++;
         $display("FAIL %s_ovf: got %b expected %b", name, o, e.ovf);
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({state_a, disp_a, val1_a, val2_a, pop_a, ovf_a, opp_a, btnp_a} !== '0) begin
         errors++;
         $display("FAIL %s: st=%0d disp=%0d v1=%0d v2=%0d op=%b ovf=%b pulses=%b%b expected all 0",
                  name, state_a, disp_a, val1_a, val2_a, pop_a, ovf_a, opp_a, btnp_a);
      end
      checks++;
      if ({state_s, disp_s, val1_s, val2_s, pop_s, ovf_s, opp_s, btnp_s} !== '0) begin
         errors++;
         $display("FAIL %s_signed: st=%0d v1=%0d ovf=%b expected all 0", name, state_s, val1_s, ovf_s);
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      btn = 10'd0;
      opcode = 5'd0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add_eq();
      set_btn(4);
      checks++;
      if (btnp_a !== 1'b1 || disp_a !== 10'd4) begin
         errors++;
         $display("FAIL btn_event: btn_pressed=%b disp=%0d expected 1 and 4", btnp_a, disp_a);
      end
      press(ADD, 1'b1);
      checks++;
      if (state_a !== 2'd1 || val1_a !== 10'd4 || disp_a !== 10'd4 || pop_a !== ADD) begin
         errors++;
         $display("FAIL add_latch: st=%0d v1=%0d disp=%0d op=%b expected 1 4 4 00001",
                  state_a, val1_a, disp_a, pop_a);
      end
      set_btn(6);
      checks++;
      if (state_a !== 2'd2 || disp_a !== 10'd6) begin
         errors++;
         $display("FAIL enter_b: st=%0d disp=%0d expected 2 6", state_a, disp_a);
      end
      sb.push_back(model(ADD, 4, 6, 10, 1'b0));
      press(EQ, 1'b1);
      check_result("add_eq", 2'd3);
      checks++;
      if (disp_a !== 10'd10 || val2_a !== 10'd6) begin
         errors++;
         $display("FAIL add_eq_disp: disp=%0d v2=%0d expected 10 6", disp_a, val2_a);
      end
   endtask

   task automatic test_chain();
      exp_t e;
      set_btn(3);
      checks++;
      if (state_a !== 2'd0) begin
         errors++;
         $display("FAIL res_to_a: got %0d expected 0", state_a);
      end
      press(MUL, 1'b1);
      set_btn(4);
      e = model(MUL, 3, 4, 10, 1'b0);
      sb.push_back(e);
      press(SUB, 1'b1);
      check_result("chain_mul", 2'd1);
      set_btn(2);
      sb.push_back(model(SUB, int'(e.val), 2, 10, 1'b0));
      press(EQ, 1'b1);
      check_result("chain_sub", 2'd3);
      checks++;
      if (pop_a !== SUB || val2_a !== 10'd2) begin
         errors++;
         $display("FAIL chain_op: op=%b v2=%0d expected 00010 2", pop_a, val2_a);
      end
   endtask

   task automatic test_overflow();
      set_btn(1000);
      press(ADD, 1'b1);
      set_btn(100);
      sb.push_back(model(ADD, 1000, 100, 10, 1'b0));
      press(EQ, 1'b1);
      check_result("ovf_add", 2'd3);
      press(CE, 1'b1);
      checks++;
      if (ovf_a !== 1'b0 || state_a !== 2'd0 || val1_a !== 10'd0) begin
         errors++;
         $display("FAIL ce_clear: ovf=%b st=%0d v1=%0d expected 0 0 0", ovf_a, state_a, val1_a);
      end
   endtask

   task automatic test_signed();
      set_btn(100);
      press(ADD, 1'b1);
      set_btn(0);
      set_btn(100);
      sb.push_back(model(ADD, 100, 100, 8, 1'b1));
      press(EQ, 1'b1);
      check_result("signed_add", 2'd3);
      set_btn(0);
      checks++;
      if (ovf_s !== 1'b0 || state_s !== 2'd0) begin
         errors++;
         $display("FAIL signed_new_calc: ovf=%b st=%0d expected 0 0", ovf_s, state_s);
      end
      press(SUB, 1'b1);
      set_btn(1);
      sb.push_back(model(SUB, 0, 1, 8, 1'b1));
      press(EQ, 1'b1);
      check_result("signed_sub", 2'd3);
   endtask

   task automatic test_held_multihot();
      logic [1:0] st0;
      st0 = state_a;
      @(negedge clk);
      opcode = 5'b00011;
      repeat (2) @(negedge clk);
      opcode = ADD;
      repeat (2) @(negedge clk);
      checks++;
      if (opp_a !== 1'b0 || state_a !== st0) begin
         errors++;
         $display("FAIL multihot_held: op_pressed=%b st=%0d expected 0 %0d", opp_a, state_a, st0);
      end
      opcode = 5'd0;
      @(negedge clk);
      press(CE, 1'b1);
      @(negedge clk);
      btn = 10'd7;
      opcode = ADD;
      @(negedge clk);
      checks++;
      if (val1_a !== 10'd7 || state_a !== 2'd1 || opp_a !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_btn: v1=%0d st=%0d op_pressed=%b expected 7 1 1",
                  val1_a, state_a, opp_a);
      end
      repeat (9) @(negedge clk);
      opcode = 5'd0;
      @(negedge clk);
   endtask

   task automatic test_clr_mid();
      set_btn(5);
      checks++;
      if (state_a !== 2'd2) begin
         errors++;
         $display("FAIL pre_clr_state: got %0d expected 2", state_a);
      end
      @(negedge clk);
      #2 clr = 1'b1;
      #1 check_zero("async_clr");
      @(negedge clk);
      clr = 1'b0;
      set_btn(2);
      press(ADD, 1'b1);
      set_btn(0);
      set_btn(2);
      sb.push_back(model(ADD, 2, 2, 10, 1'b0));
      press(EQ, 1'b1);
      check_result("after_clr", 2'd3);
   endtask

   initial begin
      test_reset();
      test_add_eq();
      test_chain();
      test_overflow();
      test_signed();
      test_held_multihot();
      test_clr_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
